branch_sequencer: RTL and testbench

- Downstream consumer of the 19-bit logic unit's comparison flags (eq, gt, lt, za, zb).
- Registers those flags on command, evaluates the conditional branch opcodes (5'b10000–5'b10111) against the registered flags, and maintains the 19-bit program counter.
- Includes a small call/return address stack.
- Feeds the instruction-fetch address to the rest of the CPU.

---
 rtl/branch_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_branch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer
// Program-counter sequencer for the 19-bit CPU. It latches the logic unit's
// comparison flags, resolves jumps, conditional branches, calls and returns
// against the previously latched flags, and keeps a small return-address stack.
// The registered pc is the instruction-fetch address for the rest of the core.
module branch_sequencer #(
    parameter int               WIDTH       = 19,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] target,
    input  logic             flag_we,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             za,
    input  logic             zb,
    output logic [WIDTH-1:0] pc,
    output logic [4:0]       flags_q,
    output logic             taken,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             err
);

    // Index width of the stack array; the pointer needs one extra bit so it
    // can represent every occupancy from 0 up to and including STACK_DEPTH.
    localparam int            AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [AW:0]   SP_FULL = (AW + 1)'(STACK_DEPTH);

    // Bit positions inside the flag register {zb,za,lt,gt,eq}.
    localparam int F_EQ = 0;
    localparam int F_GT = 1;
    localparam int F_LT = 2;
    localparam int F_ZA = 3;

    // Control-flow opcodes this block reacts to; everything else is sequential.
    typedef enum logic [4:0] {
        OP_JMP  = 5'b10000,
        OP_BEQ  = 5'b10001,
        OP_BNE  = 5'b10010,
        OP_BGT  = 5'b10011,
        OP_BLT  = 5'b10100,
        OP_BZA  = 5'b10101,
        OP_CALL = 5'b10110,
        OP_RET  = 5'b10111
    } opcode_e;

    // Architectural state.
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [AW:0]      sp_q,    sp_d;
    logic             taken_q, taken_d;
    logic             err_q,   err_d;

    // Return-address storage. Occupied entries are [0 .. sp_q-1].
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    // Helper signals for the next-state logic.
    opcode_e          op;
    logic [WIDTH-1:0] pc_inc;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             push_en;
    logic             empty;
    logic             full;

    assign op       = opcode_e'(opcode);
    assign pc_inc   = pc_q + WIDTH'(1);        // wraps naturally at 2^WIDTH
    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SP_FULL);
    assign push_idx = sp_q[AW-1:0];
    // With a power-of-two depth a full pointer has zero low bits, and the
    // modular subtract still lands on the top entry.
    assign pop_idx  = sp_q[AW-1:0] - AW'(1);

    // Next-state decode: pc source, stack pointer movement and error capture.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        pc_d    = pc_q;
        sp_d    = sp_q;
        taken_d = 1'b0;
        err_d   = err_q;
        push_en = 1'b0;

        if (en) begin
            pc_d = pc_inc;
            unique case (op)
                OP_JMP: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end
                OP_BEQ: begin
                    if (flags_q[F_EQ]) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_BNE: begin
                    if (!flags_q[F_EQ]) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_BGT: begin
                    if (flags_q[F_GT]) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_BLT: begin
                    if (flags_q[F_LT]) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_BZA: begin
                    if (flags_q[F_ZA]) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (!full) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + (AW + 1)'(1);
                        pc_d    = target;
                        taken_d = 1'b1;
                    end else begin
                        // Overflow: behave like a sequential instruction.
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        sp_d    = sp_q - (AW + 1)'(1);
                        pc_d    = stack_q[pop_idx];
                        taken_d = 1'b1;
                    end else begin
                        // Underflow: behave like a sequential instruction.
                        err_d = 1'b1;
                    end
                end
                default: begin
                    // Logic-unit and unused opcodes fall through to pc+1.
                end
            endcase
        end
    end

    // Control registers: pc, stack pointer, taken and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    // Flag register: captured on flag_we regardless of en; the branch decode
    // above always sees the value from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= {zb, za, lt, gt, eq};
        end
    end

    // Return-address array write port; the return address is pc+1 with wrap.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; entries are only read below the
        // pointer, which is reset, so stale contents are never observed.
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign taken       = taken_q;
    assign err         = err_q;
    assign stack_empty = empty;
    assign stack_full  = full;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed testbench for branch_sequencer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_branch_sequencer;

    localparam int W = 19;

    localparam logic [4:0] OP_NOP  = 5'b01000;
    localparam logic [4:0] OP_LOG  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b10001;
    localparam logic [4:0] OP_BNE  = 5'b10010;
    localparam logic [4:0] OP_BGT  = 5'b10011;
    localparam logic [4:0] OP_BLT  = 5'b10100;
    localparam logic [4:0] OP_BZA  = 5'b10101;
    localparam logic [4:0] OP_CALL = 5'b10110;
    localparam logic [4:0] OP_RET  = 5'b10111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic [4:0]   opcode = OP_NOP;
    logic [W-1:0] target = '0;
    logic         flag_we = 1'b0;
    logic         eq = 1'b0, gt = 1'b0, lt = 1'b0, za = 1'b0, zb = 1'b0;
    logic [W-1:0] pc;
    logic [4:0]   flags_q;
    logic         taken, stack_empty, stack_full, err;

    int tests_run = 0;
    int tests_failed = 0;

    branch_sequencer #(.WIDTH(W), .RESET_PC('0), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .target(target),
        .flag_we(flag_we), .eq(eq), .gt(gt), .lt(lt), .za(za), .zb(zb),
        .pc(pc), .flags_q(flags_q), .taken(taken),
        .stack_empty(stack_empty), .stack_full(stack_full), .err(err)
    );

    always #5 clk = ~clk;

    // One clock edge with the given control inputs; outputs settle 1 time unit later.
    task automatic step(input logic e, input logic [4:0] op, input logic [W-1:0] tgt);
        en = e;
        opcode = op;
        target = tgt;
        @(posedge clk);
        #1;
        flag_we = 1'b0;
    endtask

    task automatic set_flags(input logic [4:0] f);
        flag_we = 1'b1;
        {zb, za, lt, gt, eq} = f;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        tests_run++;
        if ({pc, taken, flags_q, stack_empty, stack_full, err} !== {19'h0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h taken=%b flags=%b empty=%b full=%b err=%b expected pc=0 taken=0 flags=0 empty=1 full=0 err=0",
                     pc, taken, flags_q, stack_empty, stack_full, err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, OP_NOP, 19'h12345);
            tests_run++;
            if ({pc, taken, stack_empty} !== {W'(i), 1'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL seq_%0d: pc=%h taken=%b empty=%b expected pc=%h taken=0 empty=1",
                         i, pc, taken, stack_empty, W'(i));
            end
        end
    endtask

    task automatic test_flags_branch;
        // Flag capture while stalled: flags update, pc holds at 3.
        set_flags(5'b01001);
        step(1'b0, OP_NOP, '0);
        tests_run++;
        if ({flags_q, pc} !== {5'b01001, 19'h3}) begin
            tests_failed++;
            $display("FAIL flag_capture: flags=%b pc=%h expected flags=01001 pc=3", flags_q, pc);
        end
        step(1'b1, OP_BEQ, 19'h00100);
        tests_run++;
        if ({pc, taken} !== {19'h00100, 1'b1}) begin
            tests_failed++;
            $display("FAIL beq_taken: pc=%h taken=%b expected pc=00100 taken=1", pc, taken);
        end
        step(1'b1, OP_BNE, 19'h00999);
        tests_run++;
        if ({pc, taken} !== {19'h00101, 1'b0}) begin
            tests_failed++;
            $display("FAIL bne_not_taken: pc=%h taken=%b expected pc=00101 taken=0", pc, taken);
        end
    endtask

    task automatic test_same_edge_flag;
        // Old eq=1 decides this edge even though eq=0 is being captured.
        set_flags(5'b00000);
        step(1'b1, OP_BEQ, 19'h00200);
        tests_run++;
        if ({pc, taken, flags_q} !== {19'h00200, 1'b1, 5'b00000}) begin
            tests_failed++;
            $display("FAIL same_edge_old_flags: pc=%h taken=%b flags=%b expected pc=00200 taken=1 flags=00000", pc, taken, flags_q);
        end
        step(1'b1, OP_BEQ, 19'h00300);
        tests_run++;
        if ({pc, taken} !== {19'h00201, 1'b0}) begin
            tests_failed++;
            $display("FAIL beq_after_update: pc=%h taken=%b expected pc=00201 taken=0", pc, taken);
        end
        // gt only: BGT taken, BLT and BZA fall through.
        set_flags(5'b00010);
        step(1'b1, OP_NOP, '0);
        step(1'b1, OP_BGT, 19'h00400);
        tests_run++;
        if ({pc, taken} !== {19'h00400, 1'b1}) begin
            tests_failed++;
            $display("FAIL bgt_taken: pc=%h taken=%b expected pc=00400 taken=1", pc, taken);
        end
        step(1'b1, OP_BLT, 19'h00500);
        step(1'b1, OP_BZA, 19'h00600);
        tests_run++;
        if ({pc, taken} !== {19'h00402, 1'b0}) begin
            tests_failed++;
            $display("FAIL blt_bza_not_taken: pc=%h taken=%b expected pc=00402 taken=0", pc, taken);
        end
        // lt and za: BLT and BZA taken.
        set_flags(5'b01100);
        step(1'b1, OP_NOP, '0);
        step(1'b1, OP_BLT, 19'h00500);
        step(1'b1, OP_BZA, 19'h00600);
        tests_run++;
        if ({pc, taken} !== {19'h00600, 1'b1}) begin
            tests_failed++;
            $display("FAIL blt_bza_taken: pc=%h taken=%b expected pc=00600 taken=1", pc, taken);
        end
    endtask

    task automatic test_wrap;
        step(1'b1, OP_JMP, 19'h7FFFF);
        step(1'b1, OP_LOG, 19'h00123);
        tests_run++;
        if ({pc, taken} !== {19'h00000, 1'b0}) begin
            tests_failed++;
            $display("FAIL pc_wrap: pc=%h taken=%b expected pc=00000 taken=0", pc, taken);
        end
        step(1'b1, OP_JMP, 19'h7FFFF);
        step(1'b1, OP_CALL, 19'h00050);
        tests_run++;
        if ({pc, taken, stack_empty} !== {19'h00050, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL call_at_top: pc=%h taken=%b empty=%b expected pc=00050 taken=1 empty=0", pc, taken, stack_empty);
        end
        step(1'b1, OP_RET, 19'h00777);
        tests_run++;
        if ({pc, taken, stack_empty} !== {19'h00000, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ret_wrapped_addr: pc=%h taken=%b empty=%b expected pc=00000 taken=1 empty=1", pc, taken, stack_empty);
        end
    endtask

    task automatic test_stack;
        logic [W-1:0] ret_exp [4];
        ret_exp = '{19'd31, 19'd21, 19'd11, 19'd1};
        // From pc=0: CALL 10, 20, 30, 40 push 1, 11, 21, 31.
        for (int i = 1; i <= 4; i++) step(1'b1, OP_CALL, W'(10 * i));
        tests_run++;
        if ({pc, stack_full, stack_empty, err} !== {19'd40, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stack_fill: pc=%0d full=%b empty=%b err=%b expected pc=40 full=1 empty=0 err=0", pc, stack_full, stack_empty, err);
        end
        step(1'b1, OP_CALL, 19'd99);
        tests_run++;
        if ({pc, taken, err, stack_full} !== {19'd41, 1'b0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL call_overflow: pc=%0d taken=%b err=%b full=%b expected pc=41 taken=0 err=1 full=1", pc, taken, err, stack_full);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_RET, 19'd500);
            tests_run++;
            if ({pc, taken} !== {ret_exp[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL ret_%0d: pc=%0d taken=%b expected pc=%0d taken=1", i, pc, taken, ret_exp[i]);
            end
        end
        step(1'b1, OP_RET, 19'd500);
        tests_run++;
        if ({pc, taken, err, stack_empty} !== {19'd2, 1'b0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ret_underflow: pc=%0d taken=%b err=%b empty=%b expected pc=2 taken=0 err=1 empty=1", pc, taken, err, stack_empty);
        end
    endtask

    task automatic test_stall_and_reset;
        step(1'b1, OP_JMP, 19'h00123);
        step(1'b0, OP_JMP, 19'h00777);
        tests_run++;
        if ({pc, taken, err} !== {19'h00123, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_jmp: pc=%h taken=%b err=%b expected pc=00123 taken=0 err=1", pc, taken, err);
        end
        step(1'b0, OP_CALL, 19'h00777);
        tests_run++;
        if ({pc, stack_empty} !== {19'h00123, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_call: pc=%h empty=%b expected pc=00123 empty=1", pc, stack_empty);
        end
        // Build depth 2 with nonzero flags, then reset between edges.
        set_flags(5'b10101);
        step(1'b1, OP_CALL, 19'h00010);
        step(1'b1, OP_CALL, 19'h00020);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({pc, taken, flags_q, stack_empty, stack_full, err} !== {19'h0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h taken=%b flags=%b empty=%b full=%b err=%b expected pc=0 taken=0 flags=0 empty=1 full=0 err=0",
                     pc, taken, flags_q, stack_empty, stack_full, err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        // No entry survives: RET now underflows.
        step(1'b1, OP_RET, 19'h00555);
        tests_run++;
        if ({pc, taken, err} !== {19'h1, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL ret_after_reset: pc=%h taken=%b err=%b expected pc=1 taken=0 err=1", pc, taken, err);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flags_branch();
        test_same_edge_flag();
        test_wrap();
        test_stack();
        test_stall_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
